// File: rtl/leitor_7seg_pkg.sv
// leitor_7seg_pkg
// Shared definitions for the 7-segment display reader:
//   - estado_t : reader FSM states
//   - EN_*     : active-low digit-enable codes on display[11:8]
//   - SEG_PAD  : active-low {g,f,e,d,c,b,a} patterns for digits 0..9
//   - LIMITE   : largest value that fits on the 7-bit numero output
package leitor_7seg_pkg;

  typedef enum logic [1:0] {
    SINCRONIZA = 2'd0,
    COLETA     = 2'd1,
    SAIDA      = 2'd2
  } estado_t;

  localparam logic [3:0] EN_UNI    = 4'b1110;
  localparam logic [3:0] EN_DEZ    = 4'b1101;
  localparam logic [3:0] EN_CEN    = 4'b1011;
  localparam logic [3:0] EN_QUADRO = 4'b0111;
  localparam logic [3:0] EN_NENHUM = 4'b1111;

  // Index i holds the pattern for digit i.
  localparam logic [9:0][6:0] SEG_PAD = {
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  localparam logic [9:0] LIMITE = 10'd127;

endpackage

// File: rtl/leitor_7seg_sevenSeg2bin.sv
// sevenSeg2bin
// Combinational inverse of bin2sevenSeg for digits 0..9.
//   seg   : active-low segments {g,f,e,d,c,b,a}
//   digit : decoded value (0 when the pattern is not a digit)
//   ok    : 1 when seg matches one of the ten digit patterns
module sevenSeg2bin
  import leitor_7seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       ok
);

  always_comb begin
    digit = '0;
    ok    = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (seg == SEG_PAD[i]) begin
        digit = 4'(i);
        ok    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/leitor_7seg.sv
// leitor_7seg
// Reconstructs a 0..127 value from a multiplexed 3-digit 7-segment bus.
// A frame is: marker (0111), then ones/tens/hundreds in any order, then the
// next marker, which closes the frame and opens the following one.
//   clock   : system clock, rising edge
//   zera_s  : synchronous active-high reset
//   display : [11:8] active-low digit enables, [7] ignored, [6:0] segments
//   numero  : last valid value, held between frames
//   valido  : one-cycle pulse when numero is loaded
//   erro    : one-cycle pulse when a frame is discarded
module leitor_7seg #(
  parameter int unsigned ESTAVEL = 2
) (
  input  logic        clock,
  input  logic        zera_s,
  input  logic [11:0] display,
  output logic [6:0]  numero,
  output logic        valido,
  output logic        erro
);
  import leitor_7seg_pkg::*;

  localparam logic [3:0] EST = 4'(ESTAVEL);

  // Samples drop bit 7 so it can never disturb the stability count.
  logic [10:0] amostra;
  logic [10:0] ultima;
  logic [3:0]  cnt;
  logic [3:0]  cnt_prox;
  logic        mudou;
  logic        fresco;

  logic [3:0]  en;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic        seg_ok;

  estado_t     estado;
  logic [2:0]  mascara;
  logic        invalido;
  logic [3:0]  uni;
  logic [3:0]  dez;
  logic [3:0]  cen;
  logic [9:0]  valor;
  logic        quadro_ok;

  assign en  = ultima[10:7];
  assign seg = ultima[6:0];

  sevenSeg2bin u_dec (
    .seg   (seg),
    .digit (dig),
    .ok    (seg_ok)
  );

  always_comb begin
    mudou = (amostra != ultima);
    if (mudou)
      cnt_prox = 4'd1;
    else if (cnt == EST)
      cnt_prox = cnt;
    else
      cnt_prox = cnt + 4'd1;
  end

  // fresco marks the single cycle in which ultima has just become stable;
  // a saturated count never re-triggers it, so each stable run is taken once.
  always_ff @(posedge clock) begin
    if (zera_s) begin
      amostra <= '1;
      ultima  <= '1;
      cnt     <= '0;
      fresco  <= 1'b0;
    end else begin
      amostra <= {display[11:8], display[6:0]};
      ultima  <= amostra;
      cnt     <= cnt_prox;
      fresco  <= (cnt_prox == EST) && ((cnt != EST) || mudou);
    end
  end

  always_comb begin
    valor     = 10'(cen) * 10'd100 + 10'(dez) * 10'd10 + 10'(uni);
    quadro_ok = (mascara == 3'b111) && !invalido && (valor <= LIMITE);
  end

  // The verdict is registered on the closing-marker edge, so valido/erro are
  // visible during SAIDA; SAIDA itself only clears the frame bookkeeping.
  always_ff @(posedge clock) begin
    if (zera_s) begin
      estado   <= SINCRONIZA;
      numero   <= '0;
      valido   <= 1'b0;
      erro     <= 1'b0;
      mascara  <= '0;
      invalido <= 1'b0;
      uni      <= '0;
      dez      <= '0;
      cen      <= '0;
    end else begin
      valido <= 1'b0;
      erro   <= 1'b0;
      case (estado)
        SINCRONIZA: begin
          if (fresco && en == EN_QUADRO) begin
            estado   <= COLETA;
            mascara  <= '0;
            invalido <= 1'b0;
          end
        end
        COLETA: begin
          if (fresco) begin
            case (en)
              EN_QUADRO: begin
                estado <= SAIDA;
                if (quadro_ok) begin
                  numero <= valor[6:0];
                  valido <= 1'b1;
                end else begin
                  erro <= 1'b1;
                end
              end
              EN_UNI: begin
                uni        <= dig;
                mascara[0] <= 1'b1;
                if (!seg_ok) invalido <= 1'b1;
              end
              EN_DEZ: begin
                dez        <= dig;
                mascara[1] <= 1'b1;
                if (!seg_ok) invalido <= 1'b1;
              end
              EN_CEN: begin
                cen        <= dig;
                mascara[2] <= 1'b1;
                if (!seg_ok) invalido <= 1'b1;
              end
              EN_NENHUM: ;
              default: invalido <= 1'b1;
            endcase
          end
        end
        SAIDA: begin
          mascara  <= '0;
          invalido <= 1'b0;
          estado   <= COLETA;
        end
        default: estado <= SINCRONIZA;
      endcase
    end
  end

endmodule

// File: tb/tb_leitor_7seg.sv
// tb_leitor_7seg
// Directed bench for leitor_7seg with ESTAVEL=2: a table of complete frames
// plus hand-written sequences for latency, missing digits, glitches,
// invalid enables and mid-frame reset.
module tb_leitor_7seg;

  logic        clock = 1'b0;
  logic        zera_s;
  logic [11:0] display;
  logic [6:0]  numero;
  logic        valido;
  logic        erro;

  int total = 0;
  int bad   = 0;
  int n_val = 0;
  int n_err = 0;

  localparam logic [3:0] E_U = 4'b1110;
  localparam logic [3:0] E_D = 4'b1101;
  localparam logic [3:0] E_C = 4'b1011;
  localparam logic [3:0] E_Q = 4'b0111;

  leitor_7seg #(.ESTAVEL(2)) dut (
    .clock   (clock),
    .zera_s  (zera_s),
    .display (display),
    .numero  (numero),
    .valido  (valido),
    .erro    (erro)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (valido) n_val++;
    if (erro) n_err++;
    if (valido && erro) begin
      bad++;
      $display("FAIL overlap: valido=%0b erro=%0b, required not both 1", valido, erro);
    end
  end

  function automatic logic [6:0] s(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string nome, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d required=%0d", nome, got, exp);
    end
  endtask

  task automatic hold(input logic [3:0] en, input logic [6:0] seg, input int n);
    display = {en, 1'($urandom_range(0, 1)), seg};
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic frame(input int u, input int d, input int c);
    hold(E_U, s(u), 4);
    hold(E_D, s(d), 4);
    hold(E_C, s(c), 4);
    hold(E_Q, 7'h7F, 6);
  endtask

  task automatic chk_pulses(input string nome, input int bv, input int be,
                            input int ev, input int ee);
    chk({nome, "_valido"}, n_val - bv, ev);
    chk({nome, "_erro"}, n_err - be, ee);
  endtask

  typedef struct {
    int u;
    int d;
    int c;
    int ok;
    int num;
  } vec_t;

  vec_t tab[10];

  initial begin
    int bv, be, lat;

    tab[0] = '{0, 0, 0, 1, 0};
    tab[1] = '{0, 0, 2, 0, 0};     // 200
    tab[2] = '{8, 2, 1, 0, 0};     // 128, one past the limit
    tab[3] = '{9, 9, 9, 0, 0};     // 999, would alias to 103 if truncated
    tab[4] = '{6, 2, 1, 1, 126};
    tab[5] = '{9, 8, 0, 1, 89};
    tab[6] = '{5, 6, 0, 1, 65};
    tab[7] = '{3, 4, 1, 0, 65};    // 143
    tab[8] = '{4, 3, 0, 1, 34};
    tab[9] = '{7, 2, 1, 1, 127};

    zera_s  = 1'b1;
    display = 12'hFFF;
    repeat (3) @(posedge clock);
    #1;
    zera_s = 1'b0;
    chk("reset_numero", numero, 0);
    chk("reset_valido", valido, 0);
    chk("reset_erro", erro, 0);

    // Digits before any marker are ignored; the marker only synchronises.
    bv = n_val; be = n_err;
    hold(E_U, s(1), 4);
    hold(E_D, s(1), 4);
    hold(E_C, s(0), 4);
    hold(E_Q, 7'h7F, 6);
    chk_pulses("presync", bv, be, 0, 0);
    chk("presync_numero", numero, 0);

    // 127 frame with latency measurement from the closing marker.
    bv = n_val; be = n_err;
    hold(E_U, s(7), 4);
    hold(E_D, s(2), 4);
    hold(E_C, s(1), 4);
    display = {E_Q, 1'b0, 7'h7F};
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clock);
      #1;
      if (valido && lat == 0) lat = k;
    end
    chk("latency", lat, 4);
    chk("n127_numero", numero, 127);
    chk_pulses("n127", bv, be, 1, 0);

    for (int i = 0; i < 10; i++) begin
      bv = n_val; be = n_err;
      frame(tab[i].u, tab[i].d, tab[i].c);
      chk($sformatf("tab%0d_numero", i), numero, tab[i].num);
      chk_pulses($sformatf("tab%0d", i), bv, be, tab[i].ok, 1 - tab[i].ok);
    end

    // Blank tens code.
    bv = n_val; be = n_err;
    hold(E_U, s(5), 4);
    hold(E_D, 7'b1111111, 4);
    hold(E_C, s(0), 4);
    hold(E_Q, 7'h7F, 6);
    chk("blank_numero", numero, 127);
    chk_pulses("blank", bv, be, 0, 1);

    // Missing hundreds, then a complete 42.
    bv = n_val; be = n_err;
    hold(E_U, s(5), 4);
    hold(E_D, s(5), 4);
    hold(E_Q, 7'h7F, 6);
    chk_pulses("nohund", bv, be, 0, 1);
    chk("nohund_numero", numero, 127);
    bv = n_val; be = n_err;
    frame(2, 4, 0);
    chk("n42_numero", numero, 42);
    chk_pulses("n42", bv, be, 1, 0);

    // One-cycle hundreds glitch carrying an illegal code must not be taken.
    bv = n_val; be = n_err;
    hold(E_U, s(3), 4);
    hold(E_D, s(4), 2);
    hold(E_C, 7'b1111111, 1);
    hold(E_D, s(4), 2);
    hold(E_C, s(0), 4);
    hold(E_Q, 7'h7F, 6);
    chk("glitch_numero", numero, 43);
    chk_pulses("glitch", bv, be, 1, 0);

    // Two enables low at once invalidates the frame.
    bv = n_val; be = n_err;
    hold(E_U, s(1), 4);
    hold(E_D, s(0), 4);
    hold(E_C, s(0), 4);
    hold(4'b0011, s(5), 4);
    hold(E_Q, 7'h7F, 6);
    chk("multi_numero", numero, 43);
    chk_pulses("multi", bv, be, 0, 1);

    // All enables off is ignored.
    bv = n_val; be = n_err;
    hold(E_U, s(4), 4);
    hold(4'b1111, s(8), 4);
    hold(E_D, s(6), 4);
    hold(E_C, s(0), 4);
    hold(E_Q, 7'h7F, 6);
    chk("blankall_numero", numero, 64);
    chk_pulses("blankall", bv, be, 1, 0);

    // Reset after tens captured.
    bv = n_val; be = n_err;
    hold(E_U, s(1), 4);
    hold(E_D, s(1), 4);
    zera_s = 1'b1;
    @(posedge clock);
    #1;
    zera_s = 1'b0;
    chk("midrst_numero", numero, 0);
    hold(E_C, s(1), 4);
    hold(E_Q, 7'h7F, 6);
    chk_pulses("midrst_sync", bv, be, 0, 0);
    chk("midrst_sync_numero", numero, 0);
    bv = n_val; be = n_err;
    hold(E_C, s(1), 4);
    hold(E_Q, 7'h7F, 6);
    chk_pulses("midrst_partial", bv, be, 0, 1);
    bv = n_val; be = n_err;
    frame(5, 1, 1);
    chk("midrst_n115_numero", numero, 115);
    chk_pulses("midrst_n115", bv, be, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
